// File: rtl/denise_bitplane_loader.sv
`default_nettype none
// ============================================================================
//  Module   : denise_bitplane_loader
//  Purpose  : Bitplane holding registers, snapshot-to-shifter transfer and
//             BPLCON1 scroll decode. The AGA build (8 planes, wide fetch
//             modes, 8-bit scroll) is enabled by the macro DENISE_BPL_AGA_EN.
//  Revision : 1.0  initial release
// ============================================================================
module denise_bitplane_loader (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clk7_en,
    input  logic         c1,
    input  logic         c3,
    input  logic         reg_wr,
    input  logic [7:0]   reg_addr,
    input  logic [63:0]  data_in,
    input  logic [1:0]   fmode,
    input  logic [3:0]   bpu,
    output logic         load,
    output logic [511:0] bpl_data,
    output logic [7:0]   scroll_odd,
    output logic [7:0]   scroll_even,
    output logic         overrun
);

`ifdef DENISE_BPL_AGA_EN
    localparam int         c_NUM_PLANES = 8;
    localparam logic [3:0] c_MAX_BPU    = 4'd8;
    localparam logic [1:0] c_FMODE_MASK = 2'b11;
`else
    localparam int         c_NUM_PLANES = 6;
    localparam logic [3:0] c_MAX_BPU    = 4'd6;
    localparam logic [1:0] c_FMODE_MASK = 2'b00;
`endif

    localparam logic [7:0] c_ADDR_BPL1DAT = 8'h88;
    localparam logic [7:0] c_ADDR_BPLCON1 = 8'h81;

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_ARMED = 1'b1;

    logic [0:0]  r_state;
    logic [0:0]  w_state_next;
    logic        r_load;
    logic        w_load_next;
    logic        r_overrun;
    logic        w_overrun_set;
    logic        w_snapshot;
    logic [7:0]  r_scroll_odd;
    logic [7:0]  r_scroll_even;
    logic [7:0]  w_scroll_odd_next;
    logic [7:0]  w_scroll_even_next;

    logic        w_wr;
    logic        w_dat_sel;
    logic        w_bpl1_wr;
    logic        w_con1_wr;
    logic        w_complete;
    logic [1:0]  w_fmode;
    logic [3:0]  w_bpu_eff;
    logic [63:0] w_masked;

    assign w_wr       = reg_wr & clk7_en;
    assign w_dat_sel  = (reg_addr[7:3] == c_ADDR_BPL1DAT[7:3]);
    assign w_bpl1_wr  = w_wr & (reg_addr == c_ADDR_BPL1DAT);
    assign w_con1_wr  = w_wr & (reg_addr == c_ADDR_BPLCON1);
    assign w_complete = (r_state == c_ARMED) & ~c1 & ~c3;
    assign w_fmode    = fmode & c_FMODE_MASK;
    assign w_bpu_eff  = (bpu > c_MAX_BPU) ? c_MAX_BPU : bpu;

    always_comb begin
        w_masked = '0;
        case (w_fmode)
            2'b00:        w_masked = {data_in[63:48], 48'h0};
            2'b01, 2'b10: w_masked = {data_in[63:32], 32'h0};
            default:      w_masked = data_in;
        endcase
    end

    // ------------------------------------------------------------------
    // Transfer FSM: state register, next-state logic, output logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
            r_load  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_load  <= w_load_next;
        end
    end

    // A new BPL1DAT write re-arms even on the completion edge
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_bpl1_wr)
                    w_state_next = c_ARMED;
            end
            c_ARMED: begin
                if (w_bpl1_wr)
                    w_state_next = c_ARMED;
                else if (w_complete)
                    w_state_next = c_IDLE;
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_load_next   = (w_state_next == c_ARMED);
        w_snapshot    = w_bpl1_wr;
        w_overrun_set = w_bpl1_wr & (r_state == c_ARMED) & ~w_complete;
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_overrun <= 1'b0;
        else if (w_overrun_set)
            r_overrun <= 1'b1;
    end

    // ------------------------------------------------------------------
    // BPLCON1 scroll decode
    // ------------------------------------------------------------------
`ifdef DENISE_BPL_AGA_EN
    assign w_scroll_odd_next  = {data_in[59:58], data_in[51:48], data_in[57:56]};
    assign w_scroll_even_next = {data_in[63:62], data_in[55:52], data_in[61:60]};
`else
    assign w_scroll_odd_next  = {2'b00, data_in[51:48], 2'b00};
    assign w_scroll_even_next = {2'b00, data_in[55:52], 2'b00};
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_scroll_odd  <= 8'h00;
            r_scroll_even <= 8'h00;
        end else if (w_con1_wr) begin
            r_scroll_odd  <= w_scroll_odd_next;
            r_scroll_even <= w_scroll_even_next;
        end
    end

    // ------------------------------------------------------------------
    // Per-plane holding register and shifter snapshot
    // ------------------------------------------------------------------
    for (genvar i = 0; i < 8; i++) begin : g_plane
        if (i < c_NUM_PLANES) begin : g_present
            logic [63:0] r_hold;
            logic [63:0] r_plane;
            logic        w_we;
            logic [63:0] w_src;

            assign w_we  = w_wr & w_dat_sel & (reg_addr[2:0] == 3'(i));
            // The plane written on this edge contributes its fresh value
            assign w_src = w_we ? w_masked : r_hold;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_hold  <= 64'h0;
                    r_plane <= 64'h0;
                end else begin
                    if (w_we)
                        r_hold <= w_masked;
                    if (w_snapshot)
                        r_plane <= (w_bpu_eff > 4'(i)) ? w_src : 64'h0;
                end
            end

            assign bpl_data[64*i +: 64] = r_plane;
        end else begin : g_absent
            assign bpl_data[64*i +: 64] = 64'h0;
        end
    end

    assign load        = r_load;
    assign overrun     = r_overrun;
    assign scroll_odd  = r_scroll_odd;
    assign scroll_even = r_scroll_even;

endmodule
`default_nettype wire

// File: doc/denise_bitplane_loader.md
DENISE_BITPLANE_LOADER -- requirements
Module: denise_bitplane_loader

Interface
REQ-001 SHALL have ports, one per line: name  direction  width  meaning.
- clk  in  1  35ns pixel clock
- reset_n  in  1  synchronous active-low reset
- clk7_en  in  1  7MHz clock enable; qualifies register writes
- c1, c3  in  1 each  clock phase signals
- reg_wr  in  1  register write strobe
- reg_addr  in  8  register address bits [8:1]
- data_in  in  64  bus write data, left-justified
- fmode  in  2  AGA fetch mode
- bpu  in  4  enabled plane count (0..8)
- load  out  1  shifter load request
- bpl_data  out  512  plane n (n=0 is BPL1) at [64n+63:64n]
- scroll_odd, scroll_even  out  8 each  scroll values for odd and even planes
- overrun  out  1  sticky overrun flag

REQ-002 SHALL use one clock, clk; reset_n is synchronous and active-low.

Function
REQ-003 SHALL accept a write only when reg_wr=1 and clk7_en=1.
- BPLxDAT: reg_addr 0x88+(x-1), x=1..8
- BPLCON1: reg_addr 0x81
REQ-004 SHALL mask write data by fmode before storing in plane holding register x-1.
- fmode 00: keep data_in[63:48]
- fmode 01 or 10: keep [63:32]
- fmode 11: keep [63:0]
- all masked-off bits stored as 0
REQ-005 SHALL, on a BPLCON1 write with d=data_in[63:48], set:
- scroll_odd = {d[11:10], d[3:0], d[9:8]}
- scroll_even = {d[15:14], d[7:4], d[13:12]}
REQ-006 SHALL implement an FSM with two states.
- IDLE (reset state)
- ARMED
REQ-007 SHALL handle a BPL1DAT write in any state as follows:
- store the masked data (REQ-004)
- snapshot all 8 holding registers into bpl_data, using the new BPL1 value
- zero each plane n where n >= bpu; bpu > 8 is treated as 8
- enter ARMED
REQ-008 SHALL drive load as a registered output equal to 1 exactly while in ARMED.
REQ-009 SHALL complete the transfer on the clk edge where state=ARMED and c1=0 and c3=0, then go to IDLE; shifters sample bpl_data at that same edge.
REQ-010 SHALL keep bpl_data stable between snapshots; BPL2..8 writes update the holding registers only.
REQ-011 SHALL handle a BPL1DAT write while ARMED on a non-completion edge as follows:
- overwrite the snapshot
- set overrun=1
- stay ARMED
REQ-012 SHALL handle a BPL1DAT write on the completion edge as follows:
- the completing load uses the old snapshot
- the new snapshot is latched
- state stays ARMED
- overrun is unchanged
REQ-013 SHALL keep overrun set until reset.

Reset
REQ-014 SHALL, on reset_n=0 at a clk edge, set:
- state IDLE
- load=0
- bpl_data, all holding registers, scroll_odd, scroll_even and overrun all 0
REQ-015 SHALL give reset priority over any simultaneous write or completion; a pending load is discarded.

Configuration
REQ-016 SHALL provide macro DENISE_BPL_AGA_EN.
REQ-017 SHALL behave as follows when DENISE_BPL_AGA_EN is defined: REQ-004 and REQ-005 apply, with 8 planes.
REQ-018 SHALL behave as follows when DENISE_BPL_AGA_EN is not defined:
- fmode treated as 00
- BPL7/BPL8 writes ignored; planes 6,7 of bpl_data always 0
- bpu values above 6 treated as 6
- scroll_odd = {2'b00, d[3:0], 2'b00}
- scroll_even = {2'b00, d[7:4], 2'b00}

Verification
REQ-019 SHALL cover: fmode=11, bpu=2, BPL2DAT=0x1111..., then BPL1DAT=0xAAAA_5555_0F0F_F0F0 -> plane0=0xAAAA_5555_0F0F_F0F0, plane1=0x1111..., planes2-7=0, load=1 until first c1=c3=0 edge.
REQ-020 SHALL cover: fmode=00, BPL1DAT data_in=0x1234_5678_9ABC_DEF0 -> plane0=0x1234_0000_0000_0000.
REQ-021 SHALL cover: BPLCON1 d=0xFFFF, then 0x00F3 -> first write gives scroll_odd=scroll_even=0xFF; second gives scroll_odd=0x0C, scroll_even=0x3C (AGA build).
REQ-022 SHALL cover: two BPL1DAT writes with no c1=c3=0 edge between them -> overrun=1, bpl_data holds the second value, exactly one completion.
REQ-023 SHALL cover: a BPL1DAT write on the completion edge -> load stays 1 and completes at the next phase edge with the new data.
REQ-024 SHALL cover: reset_n=0 while ARMED -> load=0 and all outputs 0 next cycle; build without DENISE_BPL_AGA_EN -> BPL8DAT write ignored and plane7=0.
